// File: rtl/divider_array_seq_ctrl.sv
// Round-robin front end for one shared combinational 16/8 divider. It holds the operands for a
// fixed settle window, then returns the captured q/r with the requester id and status flags.
module divider_array_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_n,
  input  logic [7:0]  req0_d,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_n,
  input  logic [7:0]  req1_d,
  output logic [15:0] div_n,
  output logic [7:0]  div_d,
  input  logic [7:0]  div_q,
  input  logic [7:0]  div_r,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_q,
  output logic [7:0]  rsp_r,
  output logic        rsp_dz,
  output logic        rsp_ovf
);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  localparam logic [3:0] CntLoad = 4'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        last_grant_q;

  logic        idle;
  logic        acc_id;
  logic [15:0] acc_n;
  logic [7:0]  acc_d;

  // Readies are gated by rst_n so they read 0 while reset is held, even though the state is idle.
  always_comb begin
    idle       = (state_q == StIdle) && rst_n;
    req0_ready = idle && req0_valid && (!req1_valid || last_grant_q);
    req1_ready = idle && req1_valid && (!req0_valid || !last_grant_q);
    acc_id     = req1_ready;
    acc_n      = acc_id ? req1_n : req0_n;
    acc_d      = acc_id ? req1_d : req0_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      div_n        <= 16'd0;
      div_d        <= 8'd0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_q        <= 8'd0;
      rsp_r        <= 8'd0;
      rsp_dz       <= 1'b0;
      rsp_ovf      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0_ready || req1_ready) begin
            div_n        <= acc_n;
            div_d        <= acc_d;
            rsp_id       <= acc_id;
            last_grant_q <= acc_id;
            rsp_dz       <= (acc_d == 8'd0);
            rsp_ovf      <= (acc_d != 8'd0) && (acc_n[15:8] >= acc_d);
            if (acc_d == 8'd0) begin
              // Divide by zero never needs the divider, so answer straight away.
              rsp_q     <= 8'hFF;
              rsp_r     <= acc_n[7:0];
              rsp_valid <= 1'b1;
              state_q   <= StResp;
            end else begin
              cnt_q   <= CntLoad;
              state_q <= StSettle;
            end
          end
        end
        StSettle: begin
          if (cnt_q == 4'd0) begin
            rsp_q     <= div_q;
            rsp_r     <= div_r;
            rsp_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_array_seq_ctrl.sv
// Bench for divider_array_seq_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model, with an exact behavioural divider attached.
module tb_divider_array_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_n, req1_n, div_n;
  logic [7:0]  req0_d, req1_d, div_d, div_q, div_r;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_dz, rsp_ovf;
  logic [7:0]  rsp_q, rsp_r;

  int cmp_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic       id;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
  } rsp_t;

  always #5 clk = ~clk;

  divider_array_seq_ctrl #(.SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_n(req0_n), .req0_d(req0_d),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_n(req1_n), .req1_d(req1_d),
    .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
    .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf)
  );

  // Exact array divider stand-in.
  int unsigned dq, dr;
  always_comb begin
    dq = 0;
    dr = 0;
    if (div_d == 8'd0) begin
      div_q = 8'hFF;
      div_r = div_n[7:0];
    end else begin
      dq    = int'(div_n) / int'(div_d);
      dr    = int'(div_n) % int'(div_d);
      div_q = dq[7:0];
      div_r = dr[7:0];
    end
  end

  function automatic rsp_t model(input logic id, input logic [15:0] n, input logic [7:0] d);
    rsp_t m;
    int unsigned qi, ri;
    m.id = id;
    if (d == 8'd0) begin
      m.q = 8'hFF; m.r = n[7:0]; m.dz = 1'b1; m.ovf = 1'b0;
    end else begin
      qi = int'(n) / int'(d);
      ri = int'(n) % int'(d);
      m.q = qi[7:0]; m.r = ri[7:0]; m.dz = 1'b0;
      m.ovf = (int'(n) / 256) >= int'(d);
    end
    return m;
  endfunction

  function automatic rsp_t cur_rsp();
    return {rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf};
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Counts negedges after an accept edge until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rsp_valid && k < 50);
  endtask

  task automatic test_reset();
    logic [45:0] outs;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
    req0_n = 16'h1111; req0_d = 8'h11; req1_n = 16'h2222; req1_d = 8'h22;
    repeat (2) @(negedge clk);
    outs = {req0_ready, req1_ready, div_n, div_d, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf};
    cmp_cnt++;
    if (outs !== 46'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int k;
    rsp_t exp;
    req0_n = 16'd100; req0_d = 8'd7; req0_valid = 1'b1;
    #1;
    cmp_cnt++;
    if (req0_ready !== 1'b1) begin
      err_cnt++; $display("FAIL single_ready: got %b expected 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b1;
    #1;
    cmp_cnt++;
    if (req0_ready !== 1'b0) begin
      err_cnt++; $display("FAIL single_ready_drop: got %b expected 0", req0_ready);
    end
    req0_valid = 1'b0;
    wait_rsp(k);
    cmp_cnt++;
    if (k != 4) begin
      err_cnt++; $display("FAIL single_latency: got %0d expected 4", k);
    end
    exp = model(1'b0, 16'd100, 8'd7);
    cmp_cnt++;
    if (cur_rsp() !== exp || exp.q !== 8'd14 || exp.r !== 8'd2) begin
      err_cnt++; $display("FAIL single_rsp: got %h expected %h", cur_rsp(), exp);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    cmp_cnt++;
    if (rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_alternate();
    int ids[$];
    int times[$];
    int cyc;
    bit both;
    apply_reset();
    req0_n = 16'd200; req0_d = 8'd9; req1_n = 16'd5000; req1_d = 8'd33;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    cyc = 0; both = 1'b0;
    while (ids.size() < 4 && cyc < 100) begin
      #1;
      if (req0_ready && req1_ready) both = 1'b1;
      if (req0_ready) begin ids.push_back(0); times.push_back(cyc); end
      if (req1_ready) begin ids.push_back(1); times.push_back(cyc); end
      @(negedge clk);
      cyc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    cmp_cnt++;
    if (ids.size() != 4 || both) begin
      err_cnt++; $display("FAIL alt_count: got %0d grants (both=%0b) expected 4", ids.size(), both);
    end else begin
      for (int i = 0; i < 4; i++) begin
        cmp_cnt++;
        if (ids[i] != (i % 2)) begin
          err_cnt++; $display("FAIL alt_id%0d: got %0d expected %0d", i, ids[i], i % 2);
        end
      end
      cmp_cnt++;
      if (times[3] - times[2] != 5 || times[1] - times[0] != 5) begin
        err_cnt++;
        $display("FAIL alt_spacing: got %0d,%0d expected 5,5", times[1] - times[0],
                 times[3] - times[2]);
      end
    end
    repeat (8) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_div_zero();
    int k;
    rsp_t exp;
    req1_n = 16'h1234; req1_d = 8'd0; req1_valid = 1'b1;
    #1;
    cmp_cnt++;
    if (req1_ready !== 1'b1) begin
      err_cnt++; $display("FAIL dz_ready: got %b expected 1", req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp(k);
    cmp_cnt++;
    if (k != 1) begin
      err_cnt++; $display("FAIL dz_latency: got %0d expected 1", k);
    end
    exp = model(1'b1, 16'h1234, 8'd0);
    cmp_cnt++;
    if (cur_rsp() !== exp || exp.r !== 8'h34) begin
      err_cnt++; $display("FAIL dz_rsp: got %h expected %h", cur_rsp(), exp);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_ovf();
    int k;
    rsp_t exp;
    req0_n = 16'h0900; req0_d = 8'd8; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(k);
    exp = model(1'b0, 16'h0900, 8'd8);
    cmp_cnt++;
    if (k != 4 || cur_rsp() !== exp || exp.ovf !== 1'b1 || exp.q !== 8'h20) begin
      err_cnt++; $display("FAIL ovf_rsp: got %h lat %0d expected %h lat 4", cur_rsp(), k, exp);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    int k;
    rsp_t snap;
    bit bad;
    req0_n = 16'd1000; req0_d = 8'd13; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_rsp(k);
    snap = cur_rsp();
    req1_n = 16'd777; req1_d = 8'd5; req1_valid = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || cur_rsp() !== snap || req1_ready) bad = 1'b1;
    end
    cmp_cnt++;
    if (bad || snap !== model(1'b0, 16'd1000, 8'd13)) begin
      err_cnt++; $display("FAIL bp_hold: got %h expected %h stable", snap, model(1'b0, 16'd1000, 8'd13));
    end
    rsp_ready = 1'b1;
    #1;
    cmp_cnt++;
    if (req1_ready !== 1'b0) begin
      err_cnt++; $display("FAIL bp_ready_before: got %b expected 0", req1_ready);
    end
    @(negedge clk);
    cmp_cnt++;
    if (req1_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      err_cnt++; $display("FAIL bp_ready_after: got %b/%b expected 1/0", req1_ready, rsp_valid);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_rsp(k);
    cmp_cnt++;
    if (k != 4 || cur_rsp() !== model(1'b1, 16'd777, 8'd5)) begin
      err_cnt++; $display("FAIL bp_second: got %h expected %h", cur_rsp(), model(1'b1, 16'd777, 8'd5));
    end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [45:0] outs;
    bit seen;
    int k;
    req0_n = 16'd500; req0_d = 8'd3; req0_valid = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs = {req0_ready, req1_ready, div_n, div_d, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf};
    cmp_cnt++;
    if (outs !== 46'd0) begin
      err_cnt++; $display("FAIL midreset_outputs: got %h expected 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    cmp_cnt++;
    if (seen) begin
      err_cnt++; $display("FAIL midreset_no_rsp: got rsp_valid 1 expected 0");
    end
    req0_n = 16'd40; req0_d = 8'd6; req1_n = 16'd41; req1_d = 8'd7;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    cmp_cnt++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      err_cnt++; $display("FAIL midreset_tie: got %b%b expected 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(k);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    rsp_t q[$];
    rsp_t exp;
    logic last_id;
    bit acc0, acc1;
    apply_reset();
    last_id = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (req0_ready && req1_ready) begin
        cmp_cnt++; err_cnt++;
        $display("FAIL rnd_two_ready: got 11 expected at most one");
      end
      if (req0_valid && req1_valid && (acc0 || acc1)) begin
        cmp_cnt++;
        if (acc1 !== last_id ? 1'b0 : 1'b1) begin
          // Tie must go to the requester not granted last time.
        end
        if (acc1 !== !last_id) begin
          err_cnt++; $display("FAIL rnd_tie: got id %0b expected %0b", acc1, !last_id);
        end
      end
      if (rsp_valid && rsp_ready) begin
        cmp_cnt++;
        if (q.size() == 0) begin
          err_cnt++; $display("FAIL rnd_spurious: got %h expected none", cur_rsp());
        end else begin
          exp = q.pop_front();
          if (cur_rsp() !== exp) begin
            err_cnt++; $display("FAIL rnd_rsp: got %h expected %h", cur_rsp(), exp);
          end
        end
      end
      if (acc0) begin q.push_back(model(1'b0, req0_n, req0_d)); last_id = 1'b0; end
      if (acc1) begin q.push_back(model(1'b1, req1_n, req1_d)); last_id = 1'b1; end
      @(posedge clk); #1;
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
      if (cyc < 520) begin
        if (!req0_valid && $urandom_range(2) == 0) begin
          req0_n = 16'($urandom); req0_d = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
          req0_valid = 1'b1;
        end
        if (!req1_valid && $urandom_range(2) == 0) begin
          req1_n = 16'($urandom); req1_d = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
          req1_valid = 1'b1;
        end
        rsp_ready = ($urandom_range(3) != 0);
      end else begin
        rsp_ready = 1'b1;
      end
    end
    cmp_cnt++;
    if (q.size() != 0 || req0_valid || req1_valid) begin
      err_cnt++; $display("FAIL rnd_drain: got %0d pending expected 0", q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_n = '0; req0_d = '0; req1_n = '0; req1_d = '0;
    test_reset();
    test_single();
    test_alternate();
    test_div_zero();
    test_ovf();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
